// File: rtl/sincos_cordic_pkg.sv
// Shared constants for the sine/cosine CORDIC: arctangent table, vector gain
// pre-compensation and the controller state type.
package sincos_cordic_pkg;

  // K^-1 * 2^15, so the rotated vector lands on unit magnitude in Q1.15
  localparam int CORDIC_GAIN_INV = 19898;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // atan(2^-i) scaled so that a full turn is 2^16
  function automatic logic [15:0] atan_entry(input int unsigned idx);
    case (idx)
      0:       atan_entry = 16'd8192;
      1:       atan_entry = 16'd4836;
      2:       atan_entry = 16'd2555;
      3:       atan_entry = 16'd1297;
      4:       atan_entry = 16'd651;
      5:       atan_entry = 16'd326;
      6:       atan_entry = 16'd163;
      7:       atan_entry = 16'd81;
      8:       atan_entry = 16'd41;
      9:       atan_entry = 16'd20;
      10:      atan_entry = 16'd10;
      11:      atan_entry = 16'd5;
      12:      atan_entry = 16'd3;
      13:      atan_entry = 16'd1;
      14:      atan_entry = 16'd1;
      default: atan_entry = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/sincos_cordic_stage.sv
// One combinational CORDIC micro-rotation; the shift amount selects the
// iteration so a single instance can be reused every cycle.
module sincos_cordic_stage #(
  parameter int pw_xy    = 18,
  parameter int pw_z     = 16,
  parameter int pw_shift = 4
) (
  input  logic signed [pw_xy-1:0]    x_in,
  input  logic signed [pw_xy-1:0]    y_in,
  input  logic        [pw_z-1:0]     z_in,
  input  logic        [pw_shift-1:0] shift,
  input  logic        [pw_z-1:0]     atan_step,
  output logic signed [pw_xy-1:0]    x_out,
  output logic signed [pw_xy-1:0]    y_out,
  output logic        [pw_z-1:0]     z_out
);

  logic                    rot_neg;
  logic signed [pw_xy-1:0] x_shift;
  logic signed [pw_xy-1:0] y_shift;

  // A negative residual angle rotates clockwise, otherwise counter-clockwise
  assign rot_neg = z_in[pw_z-1];
  assign x_shift = x_in >>> shift;
  assign y_shift = y_in >>> shift;

  assign x_out = rot_neg ? (x_in + y_shift) : (x_in - y_shift);
  assign y_out = rot_neg ? (y_in - x_shift) : (y_in + x_shift);
  assign z_out = rot_neg ? (z_in + atan_step) : (z_in - atan_step);

endmodule

// File: rtl/sincos_cordic.sv
// Iterative sine/cosine CORDIC, one micro-rotation per clock.
// Define SINCOS_CORDIC_SAT_EN to clamp results to +/-(2^frac - 1) instead of wrapping.
module sincos_cordic
  import sincos_cordic_pkg::*;
#(
  parameter int pw_io_width         = 16,
  parameter int pw_io_decimal_width = 15,
  parameter int p_iterations        = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [pw_io_width-1:0] ip_angle,
  output logic [pw_io_width-1:0] op_sine,
  output logic [pw_io_width-1:0] op_cosine,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam int XY_W  = pw_io_width + 2;
  localparam int CNT_W = $clog2(p_iterations);
  localparam logic signed [XY_W-1:0] X_INIT =
    XY_W'(CORDIC_GAIN_INV * (2 ** (pw_io_decimal_width - 15)));

  state_t                  state;
  logic [CNT_W-1:0]        counter;
  logic signed [XY_W-1:0]  x_reg, y_reg, x_next, y_next;
  logic [pw_io_width-1:0]  z_reg, z_next, z_init, atan_step;
  logic                    negate_reg, fold;
  logic signed [XY_W-1:0]  sin_full, cos_full, sin_res, cos_res;

  // Quadrants 1 and 2 are rotated by half a turn into [-90, +90) and the result negated
  assign fold   = (ip_angle[pw_io_width-1] != ip_angle[pw_io_width-2]);
  assign z_init = fold ? {~ip_angle[pw_io_width-1], ip_angle[pw_io_width-2:0]} : ip_angle;

  assign atan_step = pw_io_width'(atan_entry(32'(counter))) << (pw_io_width - 16);

  sincos_cordic_stage #(
    .pw_xy   (XY_W),
    .pw_z    (pw_io_width),
    .pw_shift(CNT_W)
  ) u_stage (
    .x_in     (x_reg),
    .y_in     (y_reg),
    .z_in     (z_reg),
    .shift    (counter),
    .atan_step(atan_step),
    .x_out    (x_next),
    .y_out    (y_next),
    .z_out    (z_next)
  );

  assign sin_full = negate_reg ? -y_reg : y_reg;
  assign cos_full = negate_reg ? -x_reg : x_reg;

`ifdef SINCOS_CORDIC_SAT_EN
  localparam logic signed [XY_W-1:0] SAT_HI = XY_W'((2 ** pw_io_decimal_width) - 1);
  localparam logic signed [XY_W-1:0] SAT_LO = -SAT_HI;

  function automatic logic signed [XY_W-1:0] saturate(input logic signed [XY_W-1:0] v);
    if (v > SAT_HI)      saturate = SAT_HI;
    else if (v < SAT_LO) saturate = SAT_LO;
    else                 saturate = v;
  endfunction

  assign sin_res = saturate(sin_full);
  assign cos_res = saturate(cos_full);
`else
  assign sin_res = sin_full;
  assign cos_res = cos_full;
`endif

  // Controller; outputs only move in DONE so they hold between conversions
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      negate_reg <= 1'b0;
      op_sine    <= '0;
      op_cosine  <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= ROTATE;
            counter    <= '0;
            x_reg      <= X_INIT;
            y_reg      <= '0;
            z_reg      <= z_init;
            negate_reg <= fold;
            o_busy     <= 1'b1;
          end
        end
        ROTATE: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (counter == CNT_W'(p_iterations - 1)) state <= DONE;
          else                                     counter <= counter + 1'b1;
        end
        DONE: begin
          op_sine   <= pw_io_width'(sin_res);
          op_cosine <= pw_io_width'(cos_res);
          o_valid   <= 1'b1;
          o_busy    <= 1'b0;
          counter   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_cordic.sv
// Self-checking bench for sincos_cordic against a real-valued sin/cos reference.
module tb_sincos_cordic;

  localparam int W          = 16;
  localparam int P          = 15;
  localparam int RAND_COUNT = 24;
  localparam int TOL_DIR    = 4;
  // Random sweep allows for angle-LUT quantisation plus truncating shifts
  localparam int TOL_RAND   = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_start;
  logic [W-1:0] ip_angle;
  logic [W-1:0] op_sine;
  logic [W-1:0] op_cosine;
  logic         o_valid;
  logic         o_busy;

  int checkCount = 0;
  int errorCount = 0;

  sincos_cordic #(
    .pw_io_width        (W),
    .pw_io_decimal_width(15),
    .p_iterations       (P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (i_start),
    .ip_angle (ip_angle),
    .op_sine  (op_sine),
    .op_cosine(op_cosine),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Ideal round(2^15 * sin/cos) of a phase where a full turn is 2^16, clipped
  function automatic int refWave(input int angle, input bit isSine);
    real th, v;
    int  r;
    th = 2.0 * 3.14159265358979 * real'(angle) / 65536.0;
    v  = isSine ? $sin(th) : $cos(th);
    r  = int'(32768.0 * v);
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  // Difference is taken modulo 2^16 so an unsaturated build that wraps by one LSB still compares
  task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
    int diff;
    checkCount++;
    diff = observed - expected;
    diff = ((diff % 65536) + 65536 + 32768) % 65536 - 32768;
    if (diff > tol || diff < -tol) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)", tag, observed, expected, tol);
    end
  endtask

  // One full conversion from IDLE; call #1 after a rising edge
  task automatic applyStimulus(input logic [W-1:0] angle, input int tol, input string tag);
    int cycles;
    bit seen;
    ip_angle = angle;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    checkOutput({tag, "_busy_run"}, int'(o_busy), 1, 0);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 4 * P) begin
      @(posedge clk); #1;
      cycles++;
      if (o_valid) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, cycles, P + 1, 0);
    if (seen) begin
      checkOutput({tag, "_sin"}, int'($signed(op_sine)), refWave(int'(angle), 1'b1), tol);
      checkOutput({tag, "_cos"}, int'($signed(op_cosine)), refWave(int'(angle), 1'b0), tol);
      checkOutput({tag, "_busy_done"}, int'(o_busy), 0, 0);
    end
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, int'(o_valid), 0, 0);
  endtask

  initial begin
    logic [W-1:0] directed [6];
    logic [W-1:0] sweep [$];
    int           expPulses [$];
    int           seenPulses [$];
    int           waited;
    int           pulses;

    directed = '{16'h0000, 16'h4000, 16'hC000, 16'h8000, 16'h2000, 16'h6000};

    reset    = 1'b1;
    i_start  = 1'b0;
    ip_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_sin", int'($signed(op_sine)), 0, 0);
    checkOutput("reset_cos", int'($signed(op_cosine)), 0, 0);
    checkOutput("reset_valid", int'(o_valid), 0, 0);
    checkOutput("reset_busy", int'(o_busy), 0, 0);

    foreach (directed[i])
      applyStimulus(directed[i], TOL_DIR, $sformatf("dir_%h", directed[i]));

    // Outputs must hold the last result while idle
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_hold_sin", int'($signed(op_sine)), refWave(16'h6000, 1'b1), TOL_DIR);
    checkOutput("idle_hold_cos", int'($signed(op_cosine)), refWave(16'h6000, 1'b0), TOL_DIR);
    checkOutput("idle_hold_valid", int'(o_valid), 0, 0);

    // i_start held high; a mid-rotation angle glitch must not affect the result
    for (int t = 1; t <= 40; t += P + 2)
      if (t + P + 1 <= 40) expPulses.push_back(t + P + 1);
    ip_angle = 16'h2000;
    i_start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        seenPulses.push_back(c);
        checkOutput("held_sin", int'($signed(op_sine)), refWave(16'h2000, 1'b1), TOL_DIR);
        checkOutput("held_cos", int'($signed(op_cosine)), refWave(16'h2000, 1'b0), TOL_DIR);
      end
      if (c == 4) ip_angle = 16'h6000;
      if (c == 8) ip_angle = 16'h2000;
    end
    i_start = 1'b0;
    checkOutput("held_pulse_count", seenPulses.size(), expPulses.size(), 0);
    for (int i = 0; i < expPulses.size() && i < seenPulses.size(); i++)
      checkOutput($sformatf("held_pulse_%0d", i), seenPulses[i], expPulses[i], 0);
    waited = 0;
    while (o_busy && waited < 3 * P) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("held_drain_busy", int'(o_busy), 0, 0);

    sweep.push_back(16'h3FFF);
    sweep.push_back(16'h7FFF);
    sweep.push_back(16'hBFFF);
    sweep.push_back(16'hFFFF);
    for (int i = 0; i < RAND_COUNT; i++) sweep.push_back(W'($urandom_range(0, 65535)));
    foreach (sweep[i])
      applyStimulus(sweep[i], TOL_RAND, $sformatf("rnd_%h", sweep[i]));

    // Reset while rotating aborts the conversion without a valid pulse
    ip_angle = 16'h2000;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_sin", int'($signed(op_sine)), 0, 0);
    checkOutput("abort_cos", int'($signed(op_cosine)), 0, 0);
    checkOutput("abort_busy", int'(o_busy), 0, 0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_valid) pulses++;
    end
    checkOutput("abort_no_valid", pulses, 0, 0);
    applyStimulus(16'h4000, TOL_DIR, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
